top: RTL and testbench

- Top-level serial-to-byte capture unit with an 8-entry byte queue.
- Serial bits arrive on data_in, one bit per write_in strobe, LSB first. Each group of 8 bits forms a byte.
- After a fixed hold interval the byte is pushed into a FIFO. The FIFO head is shown on data_out and popped by dequeue_in.
- status_out tells the upstream sender when a new byte may be sent.

---
 rtl/top.sv | 107 ++++++++++
 tb/tb_top.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/top.sv
// top: serial-to-byte capture with hold interval and DEPTH-byte queue
module top #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 100
) (
  input  logic       clock_1MHz,
  input  logic       rst,
  input  logic       data_in,
  input  logic       write_in,
  input  logic       enqueue_in,
  input  logic       dequeue_in,
  output logic       status_out,
  output logic [7:0] data_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic {RECV, HOLD} state_t;
  state_t            state, state_n;
  logic [2:0]        w_s, e_s, q_s;
  logic [1:0]        d_s;
  logic              wr_p, enq_p, deq_p;
  logic [3:0]        count;
  logic [7:0]        shreg;
  logic [HW-1:0]     hold;
  logic [7:0]        mem [DEPTH];
  logic [AW-1:0]     wp, rp, rp_n;
  logic [AW:0]       cnt, cnt_n;
  logic              push, pop, full, empty;
  logic [7:0]        head_n;
  assign wr_p       = w_s[1] & ~w_s[2];
  assign enq_p      = e_s[1] & ~e_s[2];
  assign deq_p      = q_s[1] & ~q_s[2];
  assign full       = cnt == (AW+1)'(DEPTH);
  assign empty      = cnt == '0;
  assign pop        = deq_p & ~empty;
  assign status_out = state == RECV;
  // Two-flop synchronizers plus a third flop for rising-edge detection; data rides alongside write
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      w_s <= '0;
      e_s <= '0;
      q_s <= '0;
      d_s <= '0;
    end else begin
      w_s <= {w_s[1:0], write_in};
      e_s <= {e_s[1:0], enqueue_in};
      q_s <= {q_s[1:0], dequeue_in};
      d_s <= {d_s[0], data_in};
    end
  end
  // Next state and push decision; a push with a concurrent pop is allowed even when full
  always_comb begin
    state_n = state;
    push    = 1'b0;
    if (state == RECV) begin
      state_n = (wr_p && count == 4'd7) ? HOLD : RECV;
    end else if ((hold == '0 || enq_p) && (!full || pop)) begin
      push    = 1'b1;
      state_n = RECV;
    end
  end
  // Deserializer state, bit assembly and hold countdown
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      state <= RECV;
      count <= '0;
      shreg <= '0;
      hold  <= '0;
    end else begin
      state <= state_n;
      if (state == RECV && wr_p) begin
        shreg[count[2:0]] <= d_s[1];
        count             <= count + 4'd1;
      end
      if (push) begin
        count <= '0;
        shreg <= '0;
        hold  <= '0;
      end else if (state == RECV && state_n == HOLD) hold <= HW'(HOLD_CYCLES);
      else if (hold != '0) hold <= hold - HW'(1);
    end
  end
  // Head after this cycle's push/pop; the pushed byte bypasses storage when it becomes the head
  always_comb begin
    rp_n   = rp + AW'(pop);
    cnt_n  = cnt + (AW+1)'(push) - (AW+1)'(pop);
    head_n = (cnt_n == '0) ? 8'h00 : (push && rp_n == wp) ? shreg : mem[rp_n];
  end
  // Queue storage
  always_ff @(posedge clock_1MHz) begin
    if (push) mem[wp] <= shreg;
  end
  // Queue pointers, occupancy and registered head
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      data_out <= 8'h00;
    end else begin
      wp       <= wp + AW'(push);
      rp       <= rp_n;
      cnt      <= cnt_n;
      data_out <= head_n;
    end
  end
endmodule

// File: tb/tb_top.sv
// tb_top: scoreboard bench for the serial byte capture queue
`timescale 1ns/1ps
module tb_top;
  localparam int HOLD = 100;
  logic       clk = 0, rst = 1, data_in = 0, write_in = 0, enqueue_in = 0, dequeue_in = 0;
  logic       status_out;
  logic [7:0] data_out;
  int         checks = 0, errors = 0, cyc = 0, fall_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last = 8'h00;
  bit         mon_en = 0;
  top #(.DEPTH(8), .HOLD_CYCLES(HOLD)) dut (
    .clock_1MHz(clk), .rst(rst), .data_in(data_in), .write_in(write_in),
    .enqueue_in(enqueue_in), .dequeue_in(dequeue_in),
    .status_out(status_out), .data_out(data_out)
  );
  always #500 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask
  task automatic send_bit(input logic b);
    data_in  = b;
    write_in = 1;
    tick(10);
    write_in = 0;
    tick(10);
  endtask
  task automatic send_byte(input logic [7:0] v);
    int n;
    for (int i = 0; i < 7; i++) send_bit(v[i]);
    data_in  = v[7];
    write_in = 1;
    n = 0;
    while (status_out && n < 8) begin
      tick();
      n++;
    end
    check("status_fall", int'(n <= 4 && !status_out), 1);
    fall_cyc = cyc;
    tick(2);
    write_in = 0;
  endtask
  task automatic wait_rise(input int bound, output int d);
    while (!status_out && cyc - fall_cyc < bound) tick();
    d = cyc - fall_cyc;
  endtask
  task automatic deq();
    dequeue_in = 1;
    tick(5);
    dequeue_in = 0;
    tick(5);
  endtask
  task automatic enq_wait(output int n);
    enqueue_in = 1;
    n = 0;
    while (!status_out && n < 8) begin
      tick();
      n++;
    end
    enqueue_in = 0;
    tick(5);
  endtask
  // Stimulus with a forked head monitor that pops the scoreboard on every data_out change
  initial begin
    int d;
    fork
      forever begin
        @(negedge clk);
        if (mon_en && data_out !== last) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL head_unexpected: got %0h, want no change", data_out);
          end else check("head", int'(data_out), int'(exp_q.pop_front()));
          last = data_out;
        end
      end
    join_none
    tick(3);
    rst = 0;
    tick();
    check("reset_status", int'(status_out), 1);
    check("reset_data", int'(data_out), 8'h00);
    mon_en = 1;
    exp_q.push_back(8'hAA);
    send_byte(8'hAA);
    repeat (3) send_bit(1'b1);
    check("hold_ignore_status", int'(status_out), 0);
    wait_rise(HOLD + 20, d);
    check("hold_len_aa", int'(d >= HOLD && d <= HOLD + 4), 1);
    send_byte(8'h5A);
    wait_rise(HOLD + 20, d);
    check("hold_len_5a", int'(d >= HOLD && d <= HOLD + 4), 1);
    exp_q.push_back(8'h5A);
    deq();
    exp_q.push_back(8'h00);
    deq();
    deq();
    check("empty_deq_data", int'(data_out), 8'h00);
    check("empty_deq_status", int'(status_out), 1);
    exp_q.push_back(8'h01);
    for (int v = 1; v <= 8; v++) begin
      send_byte(8'(v));
      wait_rise(HOLD + 20, d);
      check("hold_len_fill", int'(d >= HOLD && d <= HOLD + 4), 1);
    end
    send_byte(8'h09);
    tick(150);
    check("full_stall_status", int'(status_out), 0);
    exp_q.push_back(8'h02);
    deq();
    check("full_push_status", int'(status_out), 1);
    for (int v = 3; v <= 9; v++) begin
      exp_q.push_back(8'(v));
      deq();
    end
    exp_q.push_back(8'h00);
    deq();
    exp_q.push_back(8'h3C);
    send_byte(8'h3C);
    tick(3);
    enq_wait(d);
    check("enq_early", int'(d <= 4 && status_out), 1);
    send_byte(8'h11);
    tick(3);
    enq_wait(d);
    check("enq_second", int'(status_out), 1);
    repeat (4) send_bit(1'b1);
    exp_q.push_back(8'h00);
    rst = 1;
    tick(2);
    rst = 0;
    tick();
    check("midreset_status", int'(status_out), 1);
    check("midreset_data", int'(data_out), 8'h00);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3);
    wait_rise(HOLD + 20, d);
    check("hold_len_c3", int'(d >= HOLD && d <= HOLD + 4), 1);
    exp_q.push_back(8'h00);
    deq();
    tick(10);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
